// File: rtl/vedic8x8_seq.sv
// Sequential 8x8 unsigned multiplier. It forms one 2x2 Vedic digit product per cycle,
// so a full product takes 16 steps, and it uses valid/ready handshakes on both sides.

module vedic2x2 (
  input  logic [1:0] a_i,
  input  logic [1:0] b_i,
  output logic [3:0] p_c
);
  logic c1;

  // Urdhva-tiryagbhyam: vertical and crosswise partial products
  assign c1     = a_i[1] & b_i[0] & a_i[0] & b_i[1];
  assign p_c[0] = a_i[0] & b_i[0];
  assign p_c[1] = (a_i[1] & b_i[0]) ^ (a_i[0] & b_i[1]);
  assign p_c[2] = (a_i[1] & b_i[1]) ^ c1;
  assign p_c[3] = a_i[1] & b_i[1] & c1;
endmodule

module vedic8x8_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] prod,
  output logic        busy
);
  localparam int unsigned OP_W   = 8;
  localparam int unsigned PROD_W = 16;
  localparam int unsigned STEP_W = 4;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

  state_e              state_q, state_d;
  logic [OP_W-1:0]     a_q, a_d, b_q, b_d;
  logic [PROD_W-1:0]   acc_q, acc_d, prod_q, prod_d;
  logic [STEP_W-1:0]   step_q, step_d;
  logic                in_ready_q, in_ready_d;
  logic                out_valid_q, out_valid_d;
  logic                busy_q, busy_d;

  logic [1:0]          a_dig, b_dig;
  logic [3:0]          dig_p;
  logic [2:0]          dig_sum;
  logic [3:0]          sh;
  logic [PROD_W-1:0]   term;

  // step[3:2] picks the a-digit, step[1:0] picks the b-digit
  assign a_dig   = a_q[{step_q[3:2], 1'b0} +: 2];
  assign b_dig   = b_q[{step_q[1:0], 1'b0} +: 2];
  assign dig_sum = 3'(step_q[3:2]) + 3'(step_q[1:0]);
  assign sh      = {dig_sum, 1'b0};

  vedic2x2 u_dig (
    .a_i (a_dig),
    .b_i (b_dig),
    .p_c (dig_p)
  );

  assign term = PROD_W'(dig_p) << sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      step_q      <= '0;
      prod_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      step_q      <= step_d;
      prod_q      <= prod_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    step_d  = step_q;
    prod_d  = prod_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          step_d  = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        acc_d  = acc_q + term;
        step_d = step_q + STEP_W'(1);
        if (step_q == STEP_W'(15)) begin
          prod_d  = acc_q + term;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Status flags are registered copies of the next-state decode
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    busy_d      = (state_d != S_IDLE);
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign prod      = prod_q;
  assign busy      = busy_q;
endmodule

// File: tb/tb_vedic8x8_seq.sv
// Directed bench for vedic8x8_seq: table-driven products plus hand-written
// stall, reset-abort and handshake sequences.

module tb_vedic8x8_seq;
  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] prod;
  logic        busy;

  int total;
  int bad;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[10];

  vedic8x8_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Counts edges after the accepting edge until out_valid is seen (sampled at negedge)
  task automatic wait_result(input string name, input logic [15:0] exp);
    int cyc;
    cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      cyc = i;
      if (out_valid) break;
    end
    chk({name, " latency"}, 32'(cyc), 32'd16);
    chk({name, " prod"}, 32'(prod), 32'(exp));
  endtask

  // Drives one pair at a negedge; returns just after the accept edge, in_valid dropped
  task automatic send(input logic [7:0] av, input logic [7:0] bv);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1'b1;
    a = av;
    b = bv;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    a = 8'h00;
    b = 8'h00;
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = 8'h00;
    b = 8'h00;

    vecs[0] = '{8'hFF, 8'hFF, 16'hFE01};
    vecs[1] = '{8'h0D, 8'h0B, 16'h008F};
    vecs[2] = '{8'h00, 8'h5A, 16'h0000};
    vecs[3] = '{8'h80, 8'h02, 16'h0100};
    vecs[4] = '{8'h01, 8'h01, 16'h0001};
    vecs[5] = '{8'hA5, 8'h3C, 16'h26AC};
    vecs[6] = '{8'hFF, 8'h01, 16'h00FF};
    vecs[7] = '{8'h55, 8'hAA, 16'h3872};
    vecs[8] = '{8'h0F, 8'hF0, 16'h0E10};
    vecs[9] = '{8'h12, 8'h34, 16'h03A8};

    repeat (2) @(negedge clk);
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst prod", 32'(prod), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle no accept", 32'(busy), 32'd0);

    // Back-to-back table ops with out_ready tied high: one-cycle out_valid pulses
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      send(vecs[k].a, vecs[k].b);
      chk($sformatf("v%0d busy", k), 32'(busy), 32'd1);
      chk($sformatf("v%0d in_ready", k), 32'(in_ready), 32'd0);
      wait_result($sformatf("v%0d", k), vecs[k].exp);
      @(negedge clk);
      chk($sformatf("v%0d pulse", k), 32'(out_valid), 32'd0);
      chk($sformatf("v%0d idle", k), 32'(in_ready), 32'd1);
      chk($sformatf("v%0d hold prod", k), 32'(prod), 32'(vecs[k].exp));
    end

    // Stall in DONE with a competing pair offered the whole time
    out_ready = 1'b0;
    send(8'h0D, 8'h0B);
    wait_result("stall", 16'h008F);
    in_valid = 1'b1;
    a = 8'h07;
    b = 8'h09;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("stall%0d out_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("stall%0d prod", k), 32'(prod), 32'h008F);
      chk($sformatf("stall%0d in_ready", k), 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("handoff out_valid", 32'(out_valid), 32'd0);
    chk("handoff in_ready", 32'(in_ready), 32'd1);
    chk("handoff busy", 32'(busy), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("next accept", 32'(busy), 32'd1);
    wait_result("next", 16'h003F);
    out_ready = 1'b1;
    @(negedge clk);

    // Abort mid-run with reset, then verify no stale result appears
    send(8'hA5, 8'h3C);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort prod", 32'(prod), 32'd0);
    chk("abort out_valid", 32'(out_valid), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 25; k++) begin
        @(negedge clk);
        if (out_valid || busy) seen++;
      end
      chk("abort no result", 32'(seen), 32'd0);
    end
    send(8'h12, 8'h34);
    wait_result("post-abort", 16'h03A8);
    @(negedge clk);
    chk("post-abort pulse", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
